// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: 640x480@60Hz VGA timing, framebuffer read addressing and pipeline-aligned RGB/sync outputs
// Clock        50MHz system clock; counters advance on every other edge (25MHz pixel tick)
// Reset        synchronous, active-high
// oReadAddress {fb_y[7:0], fb_x[7:0]} read address, registered one Clock after the counters
// iColor       {R,G,B} from video memory, valid MEM_LATENCY Clocks after oReadAddress
// oVGA_*       1-bit colour pins, forced to 0 outside the visible area or outside the framebuffer
// oHSync/oVSync sync pulses with SYNC_ACTIVE polarity
// oFrameStart  one-Clock pulse on the first Clock that pixel (0,0) is presented at the pins
module vga_frame_scanner #(
  parameter int SCALE_SHIFT = 1,
  parameter int FB_DIM = 256,
  parameter int MEM_LATENCY = 0,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int H_VIS = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VIS = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oReadAddress,
  input  logic [2:0]  iColor,
  output logic        oVGA_Red,
  output logic        oVGA_Green,
  output logic        oVGA_Blue,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oFrameStart
);
  localparam logic [9:0] HV = 10'(H_VIS);
  localparam logic [9:0] HS0 = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS1 = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] HMAX = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VV = 10'(V_VIS);
  localparam logic [9:0] VS0 = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS1 = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] VMAX = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] FBD = 10'(FB_DIM);
  logic       tick;
  logic [9:0] hcnt, vcnt, fbx, fby;
  logic [3:0] flags;
  logic [3:0] fd [0:MEM_LATENCY];
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tick <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      tick <= ~tick;
      if (tick) begin
        hcnt <= (hcnt == HMAX) ? '0 : hcnt + 10'd1;
        if (hcnt == HMAX) vcnt <= (vcnt == VMAX) ? '0 : vcnt + 10'd1;
      end
    end
  end
  // flags: {frame_start, show_colour, hsync_active, vsync_active}; frame start marks only the
  // first Clock of pixel (0,0), which is the Clock where tick is still low
  always_comb begin
    fbx = hcnt >> SCALE_SHIFT;
    fby = vcnt >> SCALE_SHIFT;
    flags = {hcnt == 10'd0 && vcnt == 10'd0 && !tick,
             hcnt < HV && vcnt < VV && fbx < FBD && fby < FBD,
             hcnt >= HS0 && hcnt < HS1,
             vcnt >= VS0 && vcnt < VS1};
  end
  // fd[0] is the address-stage flag register; fd[1..] track memory latency so that
  // fd[MEM_LATENCY] lines up with iColor
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oReadAddress <= '0;
      for (int i = 0; i <= MEM_LATENCY; i++) fd[i] <= '0;
      {oVGA_Red, oVGA_Green, oVGA_Blue} <= 3'b000;
      oHSync <= ~SYNC_ACTIVE;
      oVSync <= ~SYNC_ACTIVE;
      oFrameStart <= 1'b0;
    end else begin
      oReadAddress <= {fby[7:0], fbx[7:0]};
      fd[0] <= flags;
      for (int i = 1; i <= MEM_LATENCY; i++) fd[i] <= fd[i-1];
      {oVGA_Red, oVGA_Green, oVGA_Blue} <= fd[MEM_LATENCY][2] ? iColor : 3'b000;
      oHSync <= fd[MEM_LATENCY][1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      oVSync <= fd[MEM_LATENCY][0] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      oFrameStart <= fd[MEM_LATENCY][3];
    end
  end
endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: scoreboard and directed checks for vga_frame_scanner at memory latency 0 and 1
module tb_vga_frame_scanner;
  typedef struct packed {
    logic        vis;
    logic [15:0] addr;
    logic [5:0]  pins;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wht = 1'b0;
  logic [15:0] addr0, addr1;
  logic [2:0]  col0, col1;
  logic        r0, g0, b0, hs0, vs0, fs0, r1, g1, b1, hs1, vs1, fs1;
  logic [5:0]  o0, o1;
  int          tests = 0;
  int          fails = 0;
  int          j = 0;
  int          fs_cnt = 0;
  int          mark;
  logic        was_rst;
  exp_t        q0[$], q1[$], qa[$];
  exp_t        e, x;
  vga_frame_scanner #(.MEM_LATENCY(0), .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) d0 (
    .Clock(clk), .Reset(rst), .oReadAddress(addr0), .iColor(col0),
    .oVGA_Red(r0), .oVGA_Green(g0), .oVGA_Blue(b0), .oHSync(hs0), .oVSync(vs0), .oFrameStart(fs0));
  vga_frame_scanner #(.MEM_LATENCY(1), .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) d1 (
    .Clock(clk), .Reset(rst), .oReadAddress(addr1), .iColor(col1),
    .oVGA_Red(r1), .oVGA_Green(g1), .oVGA_Blue(b1), .oHSync(hs1), .oVSync(vs1), .oFrameStart(fs1));
  assign col0 = wht ? 3'b111 : addr0[2:0];
  always @(posedge clk) col1 <= wht ? 3'b111 : addr1[2:0];
  assign o0 = {r0, g0, b0, hs0, vs0, fs0};
  assign o1 = {r1, g1, b1, hs1, vs1, fs1};
  initial forever #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  // reference: index k counts Clocks since reset release; each pixel spans two Clocks,
  // 800 pixels per line, 15 lines per frame in the reduced-height bench configuration
  function automatic exp_t exp_of(input int k, input logic w);
    exp_t r;
    int p, h, v;
    logic [2:0] c;
    p = k / 2;
    h = p % 800;
    v = (p / 800) % 15;
    r.vis = h < 640 && v < 8;
    r.addr = {8'(v / 2), 8'(h / 2)};
    c = w ? 3'b111 : 3'((h / 2) % 8);
    r.pins = {(r.vis && h / 2 < 256) ? c : 3'b000,
              !(h >= 656 && h < 752), !(v >= 10 && v < 12), h == 0 && v == 0 && k % 2 == 0};
    return r;
  endfunction
  always @(posedge clk) begin
    was_rst = rst;
    #1;
    if (was_rst) begin
      chk("rst_pins0", o0, 6'b000110);
      chk("rst_pins1", o1, 6'b000110);
      chk("rst_addr", {addr0, addr1}, 32'h0);
      q0.delete();
      q1.delete();
      qa.delete();
      j = 0;
      fs_cnt = 0;
    end else begin
      j++;
      if (fs0) fs_cnt++;
    end
    e = exp_of(j, wht);
    q0.push_back(e);
    q1.push_back(e);
    qa.push_back(e);
    if (qa.size() == 2) begin
      x = qa.pop_front();
      if (x.vis) chk("sb_addr", {addr0, addr1}, {x.addr, x.addr});
    end
    if (q0.size() == 3) begin
      x = q0.pop_front();
      chk("sb_pins0", o0, x.pins);
    end
    if (q1.size() == 4) begin
      x = q1.pop_front();
      chk("sb_pins1", o1, x.pins);
    end
  end
  task automatic wait_j(input int t);
    for (int n = 0; n < 30000 && j < t; n++) @(negedge clk);
  endtask
  initial begin
    repeat (5) @(negedge clk);
    chk("init_pins", o0, 6'b000110);
    chk("init_addr", addr0, 16'h0000);
    rst = 1'b0;
    for (int n = 0; n < 10 && !fs0; n++) @(negedge clk);
    chk("fs_first_j", j, 2);
    for (int n = 0; n < 2000 && hs0; n++) @(negedge clk);
    chk("hs_fall_j", j, 1314);
    mark = j;
    for (int n = 0; n < 2000 && !hs0; n++) @(negedge clk);
    chk("hs_width", j - mark, 192);
    for (int n = 0; n < 2000 && hs0; n++) @(negedge clk);
    chk("line_period", j - mark, 1600);
    wait_j(9621);
    chk("addr_10_6", addr0, 16'h0305);
    wait_j(9622);
    chk("rgb_10_6_lat0", {r0, g0, b0}, 3'b101);
    wait_j(9623);
    chk("rgb_10_6_lat1", {r1, g1, b1}, 3'b101);
    for (int n = 0; n < 10000 && vs0; n++) @(negedge clk);
    chk("vs_fall_j", j, 16002);
    mark = j;
    for (int n = 0; n < 10000 && !vs0; n++) @(negedge clk);
    chk("vs_width", j - mark, 3200);
    wait_j(24001);
    chk("fs_once_per_frame", fs_cnt, 1);
    wait_j(24002);
    chk("fs_frame_period", {fs0, 8'(fs_cnt)}, {1'b1, 8'd2});
    rst = 1'b1;
    wht = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_j(3402);
    chk("white_h100_v2", {r0, g0, b0}, 3'b111);
    wait_j(3403);
    chk("white_h100_v2_lat1", {r1, g1, b1}, 3'b111);
    wait_j(4402);
    chk("white_h600_fbx", {r0, g0, b0}, 3'b000);
    wait_j(4602);
    chk("white_h700_blank", {r0, g0, b0}, 3'b000);
    wait_j(5824);
    chk("white_h511", {r0, g0, b0}, 3'b111);
    wait_j(5826);
    chk("white_h512", {r0, g0, b0}, 3'b000);
    wait_j(13002);
    chk("white_v8_blank", {r0, g0, b0}, 3'b000);
    rst = 1'b1;
    wht = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_j(8801);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_pins", o0, 6'b000110);
    chk("midreset_addr", addr0, 16'h0000);
    rst = 1'b0;
    for (int n = 0; n < 10 && !fs0; n++) @(negedge clk);
    chk("midreset_fs_j", j, 2);
    wait_j(3300);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
